// File: rtl/ctrl_int_if.sv
// Interrupt-controller bus: device request lines, CPU control strobes, and the
// take/acknowledge outputs. The controller sits on the slave modport.
interface ctrl_int_if;
  // Strobe semantics: we_mask, ei, di and reti are single-cycle commands sampled
  // on the rising edge with no back-pressure; s_int and ack are one-cycle pulses
  // the datapath must consume in the cycle they are high (vec valid with s_int).
  logic [3:0] irq;
  logic       we_mask;
  logic [3:0] mask_in;
  logic       ei;
  logic       di;
  logic       reti;
  logic       s_int;
  logic [9:0] vec;
  logic [3:0] ack;
  logic       busy;
  logic [3:0] pend;

  modport master (
    output irq, we_mask, mask_in, ei, di, reti,
    input  s_int, vec, ack, busy, pend
  );

  modport slave (
    input  irq, we_mask, mask_in, ei, di, reti,
    output s_int, vec, ack, busy, pend
  );
endinterface

// File: rtl/ctrl_int.sv
// Four-source vectored interrupt controller with global enable and one level of service.
// Optional rotating arbitration when CTRL_INT_ROUND_ROBIN_EN is defined.
module ctrl_int #(
  parameter logic [9:0] VEC_BASE = 10'h3F8
) (
  input  logic       clk,
  input  logic       reset,
  ctrl_int_if.slave  bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] irq_q;
  logic [3:0] pend;
  logic [3:0] mask;
  logic       gie;
  logic [1:0] id;
  logic       busy;

  logic [3:0] rise;
  logic [3:0] cand;
  logic [3:0] clr;
  logic [1:0] win;
  logic       take_now;

`ifdef CTRL_INT_ROUND_ROBIN_EN
  logic [1:0] last;

  // Search begins one past the last serviced source, wrapping modulo 4.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    win   = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = last + 2'(k + 1);
      if (!found && cand[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (cand[k]) win = 2'(k);
    end
  end
`endif

  assign rise     = bus.irq & ~irq_q;
  assign cand     = pend & mask;
  assign take_now = gie && (cand != 4'b0000);
  assign clr      = (state == TAKE) ? (4'b0001 << id) : 4'b0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      irq_q <= 4'b0000;
      pend  <= 4'b0000;
      mask  <= 4'b0000;
      gie   <= 1'b0;
      id    <= 2'd0;
      busy  <= 1'b0;
`ifdef CTRL_INT_ROUND_ROBIN_EN
      last  <= 2'd3;
`endif
    end else begin
      irq_q <= bus.irq;
      // A new edge on the source being acknowledged must survive the clear.
      pend  <= (pend & ~clr) | rise;
      if (bus.we_mask) mask <= bus.mask_in;

      case (state)
        IDLE: begin
          if (take_now) begin
            state <= TAKE;
            id    <= win;
          end
          if (bus.reti)    gie <= 1'b1;
          else if (bus.di) gie <= 1'b0;
          else if (bus.ei) gie <= 1'b1;
        end
        TAKE: begin
          state <= SERVICE;
          busy  <= 1'b1;
          gie   <= 1'b0;
`ifdef CTRL_INT_ROUND_ROBIN_EN
          last  <= id;
`endif
        end
        SERVICE: begin
          // ei/di here shape the enable that reti then unconditionally restores.
          if (bus.reti) begin
            state <= IDLE;
            busy  <= 1'b0;
            gie   <= 1'b1;
          end else if (bus.di) begin
            gie <= 1'b0;
          end else if (bus.ei) begin
            gie <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Take outputs are suppressed during a reset cycle so an aborted take never fires.
  assign bus.s_int = (state == TAKE) && !reset;
  assign bus.ack   = bus.s_int ? (4'b0001 << id) : 4'b0000;
  assign bus.vec   = VEC_BASE + {7'b0000000, id, 1'b0};
  assign bus.busy  = busy;
  assign bus.pend  = pend;
  assign dbg_state = state;

  a_ack_onehot: assert property (@(posedge clk) bus.s_int |-> $onehot(bus.ack));
  a_no_take_in_service: assert property (@(posedge clk) disable iff (reset)
    busy |-> !bus.s_int);

endmodule

// File: tb/tb_ctrl_int.sv
// Randomized and directed bench for ctrl_int against a cycle-level behavioural model.
module tb_ctrl_int;
  localparam logic [9:0] VEC_BASE = 10'h3F8;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  ctrl_int_if bus ();

  ctrl_int #(.VEC_BASE(VEC_BASE)) dut (
    .clk       (clk),
    .reset     (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: pending set, enable, and whether a take or a service is in progress.
  logic [3:0] m_pend, m_mask, m_irq_q;
  logic       m_gie, m_taking, m_busy;
  int         m_id, m_last;
  logic [1:0] exp_q[$];
  logic [1:0] seen_q[$];

  function automatic int pick(input logic [3:0] c, input int last);
    int start;
`ifdef CTRL_INT_ROUND_ROBIN_EN
    start = (last + 1) % 4;
`else
    start = 0;
`endif
    for (int i = 0; i < 4; i++)
      if (c[(start + i) % 4]) return (start + i) % 4;
    return 0;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_mask = 0; m_irq_q = 0; m_gie = 0;
    m_taking = 0; m_busy = 0; m_id = 0; m_last = 3;
  endtask

  task automatic model_update();
    logic [3:0] edges, cleared, c;
    logic       g;
    if (rst) begin
      model_reset();
      return;
    end
    edges   = bus.irq & ~m_irq_q;
    cleared = m_taking ? (4'b0001 << m_id) : 4'b0000;
    c       = m_pend & m_mask;
    g       = m_gie;
    if (m_taking) m_gie = 0;
    else if (bus.reti) m_gie = 1;
    else if (bus.di) m_gie = 0;
    else if (bus.ei) m_gie = 1;
    if (m_taking) begin
      m_taking = 0; m_busy = 1; m_last = m_id;
    end else if (m_busy) begin
      if (bus.reti) m_busy = 0;
    end else if (g && c != 0) begin
      m_taking = 1; m_id = pick(c, m_last);
    end
    m_pend  = (m_pend & ~cleared) | edges;
    if (bus.we_mask) m_mask = bus.mask_in;
    m_irq_q = bus.irq;
  endtask

  task automatic step();
    logic exp_s;
    @(negedge clk);
    exp_s = m_taking && !rst;
    check("s_int", bus.s_int, exp_s);
    check("ack", bus.ack, exp_s ? (4'b0001 << m_id) : 4'b0000);
    if (exp_s) check("vec", bus.vec, VEC_BASE + 10'(2 * m_id));
    check("busy", bus.busy, m_busy);
    check("pend", bus.pend, m_pend);
    if (bus.s_int)
      for (int i = 0; i < 4; i++) if (bus.ack[i]) seen_q.push_back(2'(i));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    bus.we_mask = 0; bus.mask_in = 0; bus.ei = 0; bus.di = 0; bus.reti = 0;
  endtask

  initial begin
    int n_exp;
    rst = 1; bus.irq = 0; idle_inputs();
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_pend", bus.pend, 0);
    check("rst_s_int", bus.s_int, 0);
    check("rst_ack", bus.ack, 0);

    // Basic take of source 2.
    rst = 0; bus.we_mask = 1; bus.mask_in = 4'hF; bus.ei = 1; step();
    idle_inputs(); bus.irq = 4'b0100; step();
    check("t1_pend", bus.pend, 4'b0100);
    step();
    check("t1_s_int", bus.s_int, 1);
    check("t1_vec", bus.vec, 10'h3FC);
    check("t1_ack", bus.ack, 4'b0100);
    step();
    check("t1_busy", bus.busy, 1);

    // Simultaneous 1 and 3: 1 first, 3 after reti, nothing while busy.
    bus.reti = 1; bus.irq = 0; step();
    bus.reti = 0; bus.irq = 4'b1010; step();
    step();
    check("t2_vec1", bus.vec, 10'h3FA);
    step(); step(); step(); step();
    check("t2_busy", bus.busy, 1);
    check("t2_no_take", bus.s_int, 0);
    bus.reti = 1; step();
    bus.reti = 0; step();
    check("t2_s_int3", bus.s_int, 1);
    check("t2_vec3", bus.vec, 10'h3FE);
    step();
    bus.reti = 1; bus.irq = 0; step();
    bus.reti = 0;

    // Masked pending, then unmask; new edge during TAKE keeps the bit.
    bus.we_mask = 1; bus.mask_in = 4'b0000; step();
    bus.we_mask = 0; bus.irq = 4'b0001; step();
    check("t3_pend0", bus.pend[0], 1);
    step(); step();
    check("t3_masked", bus.s_int, 0);
    bus.we_mask = 1; bus.mask_in = 4'b0001; step();
    bus.we_mask = 0; bus.irq = 0; step();
    check("t3_s_int", bus.s_int, 1);
    check("t3_ack", bus.ack, 4'b0001);
    bus.irq = 4'b0001; step();
    check("t4_pend_kept", bus.pend[0], 1);
    bus.reti = 1; step();
    bus.reti = 0; step();
    check("t4_retake", bus.ack, 4'b0001);
    step();

    // Reset during SERVICE, then reset during TAKE.
    bus.irq = 0; step();
    bus.irq = 4'b0010; step();
    rst = 1; step();
    rst = 0;
    check("t5_busy", bus.busy, 0);
    check("t5_pend", bus.pend, 0);
    bus.we_mask = 1; bus.mask_in = 4'hF; step();
    bus.we_mask = 0; step(); step();
    check("t5_gie_off", bus.s_int, 0);
    bus.ei = 1; step();
    bus.ei = 0; step();
    check("t6_take", bus.s_int, 1);
    rst = 1; #1;
    check("t6_rst_s_int", bus.s_int, 0);
    check("t6_rst_ack", bus.ack, 0);
    step();
    rst = 0;

    // Two sources kept pending: service order depends on arbitration mode.
    bus.irq = 0; bus.we_mask = 1; bus.mask_in = 4'hF; bus.ei = 1; step();
    idle_inputs();
    seen_q.delete(); exp_q.delete();
`ifdef CTRL_INT_ROUND_ROBIN_EN
    exp_q = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
    exp_q = '{2'd0, 2'd0, 2'd0};
`endif
    n_exp = exp_q.size();
    for (int c = 0; c < 80 && seen_q.size() < n_exp; c++) begin
      bus.irq  = (c % 2 == 0) ? 4'b0011 : 4'b0000;
      bus.reti = m_busy;
      step();
    end
    check("order_len", seen_q.size() >= n_exp, 1);
    for (int i = 0; i < n_exp && i < seen_q.size(); i++)
      check($sformatf("order_%0d", i), seen_q[i], exp_q[i]);
    idle_inputs(); bus.irq = 0;

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) bus.irq = 4'($urandom_range(0, 15));
      bus.we_mask = ($urandom_range(0, 15) == 0);
      bus.mask_in = 4'($urandom_range(0, 15));
      bus.ei      = ($urandom_range(0, 5) == 0);
      bus.di      = ($urandom_range(0, 9) == 0);
      bus.reti    = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ctrl_int.md
CTRL_INT -- requirements
Module: ctrl_int

Interface
REQ-001 SHALL have parameter VEC_BASE, default 10'h3F8: base address of the interrupt vector table in program memory.
REQ-002 SHALL have port clk  input  1: single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-004 SHALL have port irq  input  4: interrupt request lines from I/O devices, level inputs, synchronous to clk.
REQ-005 SHALL have port we_mask  input  1: write strobe for the mask register.
REQ-006 SHALL have port mask_in  input  4: new mask value, 1 = source enabled.
REQ-007 SHALL have port ei  input  1: set global enable (GIE).
REQ-008 SHALL have port di  input  1: clear GIE.
REQ-009 SHALL have port reti  input  1: return-from-interrupt strobe, asserted in the cycle the datapath pops the stack.
REQ-010 SHALL have port s_int  output  1: one-cycle pulse forcing the PC to vec and pushing the current PC.
REQ-011 SHALL have port vec  output  10: vector address, valid while s_int = 1.
REQ-012 SHALL have port ack  output  4: one-hot, one-cycle acknowledge to the serviced source.
REQ-013 SHALL have port busy  output  1: a handler is in service.
REQ-014 SHALL have port pend  output  4: pending register, readable by the CPU.

Function
REQ-015 SHALL detect rising edges per source (irq & ~irq_q) and set the matching pend bit; pend is set regardless of the mask.
REQ-016 SHALL run an FSM with states IDLE, TAKE and SERVICE.
REQ-017 IDLE->TAKE SHALL occur when GIE = 1 and (pend & mask) != 0.
REQ-018 In TAKE (exactly 1 cycle), the FSM SHALL:
- assert s_int and ack[id];
- drive vec = VEC_BASE + 2*id;
- clear pend[id], clear GIE, latch id;
- go to SERVICE.
REQ-019 In SERVICE, busy = 1 and no further take occurs.
REQ-020 SERVICE->IDLE SHALL occur on reti; GIE is restored to 1 in the same edge.
REQ-021 reti in IDLE SHALL only set GIE; reti in TAKE SHALL be ignored.
REQ-022 Arbitration: fixed priority, source 0 highest.
REQ-023 A new edge on the source being cleared in the same cycle (set and clear together) SHALL leave the pend bit set; set wins.
REQ-024 ei and di asserted together: di wins. ei/di in SERVICE SHALL update the GIE value that is restored by reti, and reti overrides it.
REQ-025 we_mask SHALL take effect on the next edge; the arbitration decision in that same cycle uses the old mask.
REQ-026 Outputs SHALL be registered except vec, ack and s_int, which decode the TAKE state and the latched id.
REQ-027 Latency: irq edge at cycle n SHALL give pend at n+1 and s_int at n+2, given GIE = 1, the source is masked in, and the FSM is IDLE.

Reset
REQ-028 On reset, the block SHALL clear state to IDLE, pend = 0, mask = 0, GIE = 0, irq_q = 0, id = 0, s_int = 0, ack = 0, busy = 0.
REQ-029 Reset asserted in TAKE or SERVICE SHALL abort the take or service with no ack or s_int in the reset cycle.

Configuration
REQ-030 With macro CTRL_INT_ROUND_ROBIN_EN defined, arbitration SHALL be rotating: search starts at (last serviced id + 1) mod 4, and the pointer resets to 3 so source 0 wins first.
REQ-031 Without CTRL_INT_ROUND_ROBIN_EN, arbitration SHALL be the fixed priority of REQ-022, with no rotation pointer in the design.

Verification
REQ-032 Reset, mask = 4'hF, ei, irq[2] rises -> pend = 4'b0100 next cycle; one cycle later s_int = 1, vec = 10'h3FC, ack = 4'b0100; then busy = 1.
REQ-033 irq[1] and irq[3] rise together with GIE = 1 -> vec = 10'h3FA first. After reti, source 3 is taken with vec = 10'h3FE; no take occurs while busy.
REQ-034 mask = 4'b0000, irq[0] edge -> pend[0] = 1 and s_int stays 0. Writing mask = 4'b0001 -> s_int two cycles after the write.
REQ-035 Same-cycle clear and new edge on source 0 during TAKE -> pend[0] = 1 after TAKE, serviced again after reti.
REQ-036 Reset asserted while in SERVICE -> busy = 0, GIE = 0, pend = 0 on the next cycle.
REQ-037 With CTRL_INT_ROUND_ROBIN_EN, sources 0 and 1 kept continuously pending -> service order 0, 1, 0, 1; without the macro, order 0, 0, 0.
